// File: rtl/lift_pkg.sv
// Shared definitions for the lift controller: state encodings and default sizing.
package lift_pkg;

  localparam int DEF_N_FLOORS    = 8;
  localparam int DEF_MOVE_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES = 3;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_MOVE = 2'd1;
  localparam logic [STATE_W-1:0] ST_DOOR = 2'd2;

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter shared by travel and door timing; done while the count is zero.
module lift_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/lift_ctrl.sv
// Single-car lift controller: collects hall/car requests and serves them in SCAN order.
module lift_ctrl
  import lift_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
  parameter int FLOOR_W     = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [N_FLOORS-1:0] car_req,
  input  logic                door_hold_i,
  output logic [FLOOR_W-1:0]  floor_o,
  output logic                dir_up_o,
  output logic                door_open_o,
  output logic                busy_o,
  output logic [N_FLOORS-1:0] pending_o
);

  localparam int T_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0] MOVE_LOAD = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_LOAD = TMR_W'(DOOR_CYCLES - 1);
  // A held cycle counts as the first of a fresh DOOR_CYCLES window.
  localparam bit               HOLD_EXTENDS = (DOOR_CYCLES > 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD    = TMR_W'(HOLD_EXTENDS ? DOOR_CYCLES - 2 : 0);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(N_FLOORS - 1);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic                dir_up_q, dir_up_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [N_FLOORS-1:0] above, below;
  logic                req_ahead, req_behind;
  logic                tmr_load, tmr_done;
  logic [TMR_W-1:0]    tmr_value;

  lift_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above[i] = pending_q[i] && (i > int'(floor_q));
      below[i] = pending_q[i] && (i < int'(floor_q));
    end
    req_ahead  = dir_up_q ? |above : |below;
    req_behind = dir_up_q ? |below : |above;
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q[floor_q]) begin
          state_d   = ST_DOOR;
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (req_ahead || req_behind) begin
          state_d   = ST_MOVE;
          dir_up_d  = req_ahead ? dir_up_q : ~dir_up_q;
          tmr_load  = 1'b1;
          tmr_value = MOVE_LOAD;
        end
      end
      ST_MOVE: begin
        if (tmr_done) begin
          floor_d = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          if (pending_q[floor_d]) begin
            state_d   = ST_DOOR;
            tmr_load  = 1'b1;
            tmr_value = DOOR_LOAD;
          end else if (dir_up_q ? (floor_d != TOP_FLOOR) : (floor_d != '0)) begin
            tmr_load  = 1'b1;
            tmr_value = MOVE_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        if (door_hold_i && HOLD_EXTENDS) begin
          tmr_load  = 1'b1;
          tmr_value = HOLD_LOAD;
        end else if (tmr_done) begin
          if (req_ahead || req_behind) begin
            state_d   = ST_MOVE;
            dir_up_d  = req_ahead ? dir_up_q : ~dir_up_q;
            tmr_load  = 1'b1;
            tmr_value = MOVE_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The cleared bit is the floor where the door is, or is about to be, open.
  always_comb begin
    pending_d = pending_q | call_req | car_req;
    if (state_d == ST_DOOR || state_q == ST_DOOR) begin
      pending_d[floor_d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      floor_q   <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
    end
  end

  assign floor_o     = floor_q;
  assign dir_up_o    = dir_up_q;
  assign door_open_o = (state_q == ST_DOOR);
  assign busy_o      = (state_q != ST_IDLE);
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_lift_ctrl.sv
// Self-checking bench for lift_ctrl: door-service events are scoreboarded against expected floor/direction/timing.
module tb_lift_ctrl;

  localparam int N = 8;
  localparam int M = 4;
  localparam int D = 3;

  typedef struct {
    int floor;
    int dir;
    int start;
    int len;
  } door_ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] call_req;
  logic [N-1:0] car_req;
  logic         door_hold_i;
  logic [2:0]   floor_o;
  logic         dir_up_o;
  logic         door_open_o;
  logic         busy_o;
  logic [N-1:0] pending_o;

  int       cyc = 0;
  int       n_cmp = 0;
  int       n_bad = 0;
  door_ev_t exp_q[$];

  lift_ctrl #(
    .N_FLOORS    (N),
    .MOVE_CYCLES (M),
    .DOOR_CYCLES (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .call_req    (call_req),
    .car_req     (car_req),
    .door_hold_i (door_hold_i),
    .floor_o     (floor_o),
    .dir_up_o    (dir_up_o),
    .door_open_o (door_open_o),
    .busy_o      (busy_o),
    .pending_o   (pending_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // Door monitor: every completed door opening is matched against the scoreboard.
  logic     door_prev = 1'b0;
  int       d_start, d_floor, d_dir;
  door_ev_t ev;
  always @(negedge clk) begin
    if (door_open_o && !door_prev) begin
      d_start = cyc;
      d_floor = int'(floor_o);
      d_dir   = int'(dir_up_o);
    end
    if (door_open_o) check("busy_in_door", int'(busy_o), 1);
    if (!door_open_o && door_prev) begin
      check("door_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        check("door_floor", d_floor, ev.floor);
        check("door_dir", d_dir, ev.dir);
        check("door_start", d_start, ev.start);
        check("door_len", cyc - d_start, ev.len);
      end
    end
    door_prev = door_open_o;
  end

  task automatic push_door(input int f, input int dir, input int st, input int len);
    door_ev_t e;
    e.floor = f;
    e.dir   = dir;
    e.start = st;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  // One-cycle request pulse; s is the cycle count just before the sampling edge.
  task automatic drive_req(input logic [N-1:0] call, input logic [N-1:0] car, output int s);
    @(posedge clk); #1;
    s        = cyc;
    call_req = call;
    car_req  = car;
    @(posedge clk); #1;
    call_req = '0;
    car_req  = '0;
  endtask

  task automatic at_cycle(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk); #1;
      n++;
      ok = (busy_o == 1'b0) && (exp_q.size() == 0);
    end
    check("idle_reached", int'(ok), 1);
    if (!ok) exp_q.delete();
  endtask

  initial begin
    int s;
    rst         = 1'b1;
    call_req    = 8'h0F;
    car_req     = 8'hF0;
    door_hold_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_floor", int'(floor_o), 0);
    check("rst_dir", int'(dir_up_o), 1);
    check("rst_door", int'(door_open_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_pending", int'(pending_o), 0);
    @(posedge clk); #1;
    rst      = 1'b0;
    call_req = '0;
    car_req  = '0;
    @(negedge clk);
    check("pend_after_rst", int'(pending_o), 0);

    // Request at the current floor while idle.
    drive_req('0, 8'h01, s);
    push_door(0, 1, s + 2, D);
    at_cycle(s + 1);
    check("local_pending", int'(pending_o), 8'h01);
    check("local_busy_pre", int'(busy_o), 0);
    wait_idle(50);
    check("local_pend_clear", int'(pending_o), 0);

    // Travel up five floors, one step every M cycles.
    drive_req(8'h20, '0, s);
    push_door(5, 1, s + 2 + 5 * M, D);
    for (int i = 1; i <= 5; i++) begin
      at_cycle(s + 1 + M * i);
      check("floor_pre_step", int'(floor_o), i - 1);
      check("move_dir_up", int'(dir_up_o), 1);
      at_cycle(s + 2 + M * i);
      check("floor_post_step", int'(floor_o), i);
    end
    wait_idle(100);
    check("up_end_floor", int'(floor_o), 5);

    // SCAN: from floor 5 heading up with requests at 7 and 2.
    drive_req('0, 8'h84, s);
    push_door(7, 1, s + 2 + 2 * M, D);
    push_door(2, 0, s + 2 + 2 * M + D + 5 * M, D);
    at_cycle(s + 1);
    check("scan_pending", int'(pending_o), 8'h84);
    at_cycle(s + 2 + 2 * M + D);
    check("scan_reverse_dir", int'(dir_up_o), 0);
    check("scan_mid_pending", int'(pending_o), 8'h04);
    wait_idle(150);
    check("scan_end_floor", int'(floor_o), 2);

    // Door hold for 10 cycles plus an absorbed same-floor request.
    drive_req('0, 8'h04, s);
    push_door(2, 0, s + 2, 12);
    @(posedge clk); #1;
    door_hold_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    car_req = 8'h04;
    @(posedge clk); #1;
    car_req = '0;
    repeat (6) @(posedge clk); #1;
    door_hold_i = 1'b0;
    at_cycle(s + 13);
    check("hold_door_open", int'(door_open_o), 1);
    check("hold_absorbed", int'(pending_o), 0);
    wait_idle(100);
    at_cycle(s + 16);
    check("hold_no_reopen", int'(door_open_o), 0);
    check("hold_pend_final", int'(pending_o), 0);

    // Reset while travelling between floors 3 and 4.
    drive_req(8'h80, '0, s);
    at_cycle(s + 7);
    check("pre_rst_floor", int'(floor_o), 3);
    check("pre_rst_pending", int'(pending_o), 8'h80);
    check("pre_rst_busy", int'(busy_o), 1);
    rst     = 1'b1;
    car_req = 8'h10;
    @(posedge clk); #1;
    rst     = 1'b0;
    car_req = '0;
    at_cycle(s + 8);
    check("mrst_floor", int'(floor_o), 0);
    check("mrst_dir", int'(dir_up_o), 1);
    check("mrst_door", int'(door_open_o), 0);
    check("mrst_busy", int'(busy_o), 0);
    check("mrst_pending", int'(pending_o), 0);
    at_cycle(s + 14);
    check("mrst_stays_idle", int'(busy_o), 0);
    check("mrst_stays_floor", int'(floor_o), 0);

    // Every floor requested at once: served bottom to top exactly once each.
    drive_req('0, 8'hFF, s);
    for (int f = 0; f < N; f++) push_door(f, 1, s + 2 + f * (D + M), D);
    wait_idle(200);
    check("all_end_floor", int'(floor_o), 7);
    check("all_pend_clear", int'(pending_o), 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lift_ctrl.md
LIFT_CTRL -- requirements
Module: lift_ctrl

Interface
REQ-001 Parameter N_FLOORS, default 8: number of floors served, range 2..16.
REQ-002 Parameter MOVE_CYCLES, default 4: clock cycles spent travelling one floor, at least 1.
REQ-003 Parameter DOOR_CYCLES, default 3: minimum clock cycles the door stays open, at least 1.
REQ-004 Parameter FLOOR_W, default $clog2(N_FLOORS): width of floor-index signals.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 call_req  input  N_FLOORS  hall-call buttons, one bit per floor; level or pulse.
REQ-008 car_req  input  N_FLOORS  in-car floor buttons, one bit per floor; level or pulse.
REQ-009 door_hold_i  input  1  door-hold button; effective only while the door is open.
REQ-010 floor_o  output  FLOOR_W  current car floor, always less than N_FLOORS.
REQ-011 dir_up_o  output  1  direction of travel: 1 = up, 0 = down.
REQ-012 door_open_o  output  1  high exactly while state = DOOR.
REQ-013 busy_o  output  1  high whenever state is not IDLE.
REQ-014 pending_o  output  N_FLOORS  registered outstanding-request vector.

Function
REQ-015 The pending register SHALL update every cycle as: pending = pending | call_req | car_req, except that bit floor_o is forced to 0 in any cycle where the next state is DOOR or the current state is DOOR.
REQ-016 The state machine SHALL have three states: IDLE, MOVE and DOOR.
REQ-017 IDLE transitions, evaluated against registered pending:
- pending[floor_o] set -> go to DOOR.
- else any request in the dir_up_o direction -> go to MOVE, keep direction.
- else any request in the opposite direction -> toggle dir_up_o, go to MOVE.
- else stay in IDLE.
REQ-018 MOVE SHALL last exactly MOVE_CYCLES cycles per floor; on the final cycle, floor_o increments (up) or decrements (down) by 1.
REQ-019 On arrival at a floor:
- pending at the new floor -> go to DOOR.
- else -> start another MOVE step in the same direction.
REQ-020 MOVE SHALL be entered only when a request lies ahead, so floor_o never leaves the range 0..N_FLOORS-1.
REQ-021 DOOR SHALL last DOOR_CYCLES cycles; the door timer reloads to DOOR_CYCLES every cycle that door_hold_i is high.
REQ-022 On DOOR expiry, the IDLE rules of REQ-017 apply, except that a request at the current floor is already absorbed and does not reopen the door.
- Result: SCAN order, i.e. all requests in the current direction are served before reversing.
REQ-023 Latency: a request sampled at edge k sets pending at edge k; for the current floor in IDLE, door_open_o rises at edge k+1.
REQ-024 A request for the current floor while the door is open SHALL be absorbed; it neither reopens nor extends the door.
REQ-025 A request for the current floor arriving simultaneously with MOVE start SHALL remain pending and be served later.
REQ-026 Request bits at or above N_FLOORS do not exist; no floor index at or above N_FLOORS is ever produced.

Reset
REQ-027 While rst is high at an edge: state = IDLE, floor_o = 0, dir_up_o = 1, door_open_o = 0, busy_o = 0, pending = 0, and all timers = 0.
REQ-028 Requests presented during reset SHALL be discarded.
REQ-029 Reset asserted mid-MOVE or mid-DOOR SHALL take effect at the next edge with no partial floor update.

Structure
REQ-030 Package lift_pkg SHALL hold the state enumeration (IDLE, MOVE, DOOR) and the default values of N_FLOORS, MOVE_CYCLES and DOOR_CYCLES.
REQ-031 One sub-module, lift_timer, SHALL be used: a loadable down-counter with load, value and done signals, shared by the MOVE and DOOR timing.
REQ-032 The "request above" and "request below" detection SHALL be combinational masks of pending against floor_o; no priority encoder is needed.

Verification (N_FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=3)
REQ-033 Reset, then pulse car_req=8'h01 -> door_open_o high for 3 cycles at floor 0, busy_o high for the same 3 cycles, pending_o returns to 0.
REQ-034 From floor 0 idle, pulse call_req=8'h20 -> floor_o steps 1,2,3,4,5 every 4 cycles with dir_up_o=1, then the door opens for 3 cycles, then IDLE.
REQ-035 At floor 5 moving up with pending bits 2 and 7 -> serves floor 7 first, reverses, serves floor 2 with dir_up_o=0, then IDLE.
REQ-036 door_hold_i high for 10 cycles starting in the first DOOR cycle -> door open for 12 cycles total; a car_req for the current floor during DOOR is absorbed with no reopen.
REQ-037 rst pulsed during MOVE between floors 3 and 4 with pending=8'h80 -> next cycle floor_o=0, state IDLE, pending_o=0, all outputs at reset values.
REQ-038 car_req=8'hFF held for 1 cycle at floor 0 -> floors 0..7 each served exactly once in ascending order.
